// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Requester indices and the read-tracking FSM states.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request always wins,
// a tie goes to the requester named by ptr.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_valid,
    output logic       winner
);

    assign gnt_valid = |req;

    always_comb begin
        winner = REQ_CORE;
        if (req == 2'b11)
            winner = ptr;
        else if (req[REQ_LOADER])
            winner = REQ_LOADER;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the core
// and the loader, tracking one-cycle read latency.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [2:0]            r0_size,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,

    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [2:0]            r1_size,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_size,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    arb_state_t state;
    logic       ptr;
    logic       owner;
    logic       gntValid;
    logic       winner;
    logic       readPhase;
    logic [1:0] reqVec;

    // Requests are only visible in IDLE and never while reset is held.
    assign reqVec = (!rst && state == IDLE) ? {r1_req, r0_req} : 2'b00;

    rr_pick2 picker (
        .req       (reqVec),
        .ptr       (ptr),
        .gnt_valid (gntValid),
        .winner    (winner)
    );

    assign r0_gnt = gntValid && (winner == REQ_CORE);
    assign r1_gnt = gntValid && (winner == REQ_LOADER);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = '0;
        if (gntValid) begin
            mem_en = 1'b1;
            if (winner == REQ_LOADER) begin
                mem_we    = r1_we;
                mem_addr  = r1_addr;
                mem_wdata = r1_wdata;
                mem_size  = r1_size;
            end else begin
                mem_we    = r0_we;
                mem_addr  = r0_addr;
                mem_wdata = r0_wdata;
                mem_size  = r0_size;
            end
        end
    end

    // A reset arriving mid-read drops the data on the floor.
    assign readPhase = !rst && state == RD_WAIT;
    assign busy      = readPhase;

    assign r0_rvalid = readPhase && (owner == REQ_CORE);
    assign r1_rvalid = readPhase && (owner == REQ_LOADER);
    assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
    assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b0;
            owner <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gntValid) begin
                        ptr <= ~winner;
                        if (!mem_we) begin
                            owner <= winner;
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle reference model compare
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic [2:0]    r0_size, r1_size;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_size;
    logic [DW-1:0] memRdata = '0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_size(r0_size), .r0_gnt(r0_gnt),
        .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_size(r1_size), .r1_gnt(r1_gnt),
        .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_rdata(memRdata), .busy(busy)
    );

    // Memory returns address+1 one cycle after it is presented.
    always @(posedge clk) memRdata <= 32'(mem_addr) + 32'd1;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding read at most, fair tie-break.
    logic          mPend = 1'b0;
    logic          mOwner = 1'b0;
    logic          mPtr = 1'b0;
    logic [DW-1:0] mData = '0;

    always @(negedge clk) begin
        logic [122:0] act, exp;
        logic g0, g1, v0, v1, en, we, bz, w, any;
        logic [DW-1:0] d0, d1, wd;
        logic [AW-1:0] ad;
        logic [2:0] sz;
        {g0, g1, v0, v1, en, we, bz} = '0;
        {d0, d1, wd, ad, sz} = '0;
        w = 1'b0;
        any = 1'b0;
        if (!rst) begin
            if (mPend) begin
                bz = 1'b1;
                if (mOwner) begin v1 = 1'b1; d1 = mData; end
                else begin v0 = 1'b1; d0 = mData; end
            end else if (r0_req || r1_req) begin
                any = 1'b1;
                w = (r0_req && r1_req) ? mPtr : r1_req;
                en = 1'b1;
                g0 = !w;
                g1 = w;
                we = w ? r1_we : r0_we;
                ad = w ? r1_addr : r0_addr;
                wd = w ? r1_wdata : r0_wdata;
                sz = w ? r1_size : r0_size;
            end
        end
        act = {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_size, busy};
        exp = {g0, g1, v0, v1, d0, d1, en, we, ad, wd, sz, bz};
        check("cycle outputs", 128'(act), 128'(exp));
        if (rst) begin
            mPend = 1'b0;
            mPtr  = 1'b0;
        end else if (mPend) begin
            mPend = 1'b0;
        end else if (any) begin
            mPtr = !w;
            if (!we) begin
                mPend  = 1'b1;
                mOwner = w;
                mData  = 32'(ad) + 32'd1;
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setR0(logic req, logic we, logic [AW-1:0] a,
                         logic [DW-1:0] d, logic [2:0] s);
        r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d; r0_size = s;
    endtask

    task automatic setR1(logic req, logic we, logic [AW-1:0] a,
                         logic [DW-1:0] d, logic [2:0] s);
        r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d; r1_size = s;
    endtask

    initial begin
        int seq[6];
        rst = 1'b1;
        setR0(1'b1, 1'b0, 17'h10, '0, 3'b010);
        setR1(1'b1, 1'b0, 17'h20, '0, 3'b010);

        // Reset held two cycles with both requesting.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst gnt", {r0_gnt, r1_gnt}, 2'b00);
            check("rst en/busy", {mem_en, busy, r0_rvalid, r1_rvalid}, 4'b0);
            nextCycle();
        end
        rst = 1'b0;

        // Simultaneous reads after reset.
        @(negedge clk);
        check("rd N ptr", dut.ptr, 1'b0);
        check("rd N gnt", {r0_gnt, r1_gnt}, 2'b10);
        check("rd N addr", mem_addr, 17'h10);
        nextCycle();
        setR0(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("rd N+1", {r0_rvalid, busy, r1_gnt}, 3'b110);
        check("rd N+1 data", r0_rdata, 32'h11);
        nextCycle();
        @(negedge clk);
        check("rd N+2 gnt", {r0_gnt, r1_gnt}, 2'b01);
        check("rd N+2 addr", mem_addr, 17'h20);
        nextCycle();
        setR1(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("rd N+3", {r1_rvalid, r0_rvalid}, 2'b10);
        check("rd N+3 data", r1_rdata, 32'h21);
        nextCycle();

        // Single write.
        setR0(1'b1, 1'b1, 17'h100, 32'hDEADBEEF, 3'b010);
        @(negedge clk);
        check("wr gnt", {r0_gnt, mem_we, mem_en}, 3'b111);
        check("wr addr", mem_addr, 17'h100);
        check("wr data", mem_wdata, 32'hDEADBEEF);
        check("wr size", mem_size, 3'b010);
        nextCycle();
        setR0(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check("wr ptr", dut.ptr, 1'b1);
        nextCycle();

        // Solo streaming from the loader.
        for (int i = 0; i < 4; i++) begin
            setR1(1'b1, 1'b1, AW'(17'h200 + 4 * i), 32'(i), 3'b010);
            @(negedge clk);
            check("solo gnt", {r1_gnt, r0_gnt}, 2'b10);
            check("solo addr", mem_addr, AW'(17'h200 + 4 * i));
            nextCycle();
        end
        setR1(1'b0, 1'b0, '0, '0, '0);

        // Contention: both writing continuously.
        setR0(1'b1, 1'b1, 17'h300, 32'hA0A0A0A0, 3'b010);
        setR1(1'b1, 1'b1, 17'h400, 32'hB1B1B1B1, 3'b010);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seq[i] = r1_gnt ? 1 : (r0_gnt ? 0 : 9);
            check("fair en", mem_en, 1'b1);
            nextCycle();
        end
        for (int i = 0; i < 6; i++)
            check("fair order", 128'(seq[i]), 128'(i % 2));
        setR0(1'b0, 1'b0, '0, '0, '0);
        setR1(1'b0, 1'b0, '0, '0, '0);

        // Reset arriving while a loader read is outstanding.
        setR1(1'b1, 1'b0, 17'h40, '0, 3'b010);
        @(negedge clk);
        check("mid gnt", r1_gnt, 1'b1);
        nextCycle();
        setR1(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        check("mid rvalid", {r1_rvalid, busy}, 2'b00);
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        check("mid state", dut.state, IDLE);
        check("mid ptr", dut.ptr, 1'b0);
        check("mid quiet", {r1_rvalid, busy, mem_en}, 3'b000);
        nextCycle();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
